// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and widths for the shared-multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned RES_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/mul_arb_if.sv
// mul_arb_if: requester-side and multiplier-side signals of the arbiter.
// slave is the arbiter's view, master the view of the surrounding logic.
interface mul_arb_if
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) ();

  logic [N_REQ-1:0]      req_i;
  logic [N_REQ*OP_W-1:0] a_bi;
  logic [N_REQ*OP_W-1:0] b_bi;
  logic [N_REQ-1:0]      gnt_o;
  logic [N_REQ-1:0]      done_o;
  logic [RES_W-1:0]      y_bo;
  logic                  busy_o;
  logic                  mul_start_o;
  logic [OP_W-1:0]       mul_a_bo;
  logic [OP_W-1:0]       mul_b_bo;
  logic                  mul_busy_i;
  logic [RES_W-1:0]      mul_y_bi;

  modport slave (
    input  req_i, a_bi, b_bi, mul_busy_i, mul_y_bi,
    output gnt_o, done_o, y_bo, busy_o, mul_start_o, mul_a_bo, mul_b_bo
  );

  modport master (
    output req_i, a_bi, b_bi, mul_busy_i, mul_y_bi,
    input  gnt_o, done_o, y_bo, busy_o, mul_start_o, mul_a_bo, mul_b_bo
  );

endinterface

// File: rtl/mul_arb_pick.sv
// mul_arb_pick: combinational winner selection.
// With MUL_ARB_RR_EN defined the scan starts at ptr and wraps; otherwise the
// lowest requesting index wins and no ptr port exists.
module mul_arb_pick
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifdef MUL_ARB_RR_EN
  input  logic [ID_W-1:0]  ptr,
`endif
  output logic [N_REQ-1:0] win_onehot_c,
  output logic [ID_W-1:0]  win_idx_c,
  output logic             any_c
);

`ifdef MUL_ARB_RR_EN
  // Index base+off reduced modulo N_REQ (off < N_REQ, base < N_REQ).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction
`endif

  // First requester found in scan order.
  always_comb begin
    win_onehot_c = '0;
    win_idx_c    = '0;
    any_c        = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef MUL_ARB_RR_EN
      if (!any_c && req[wrap_idx(ptr, i)]) begin
        any_c     = 1'b1;
        win_idx_c = wrap_idx(ptr, i);
      end
`else
      if (!any_c && req[ID_W'(i)]) begin
        any_c     = 1'b1;
        win_idx_c = ID_W'(i);
      end
`endif
    end
    if (any_c) win_onehot_c = N_REQ'(1) << win_idx_c;
  end

endmodule

// File: rtl/mul_arb.sv
// mul_arb: lets N_REQ requesters share one sequential 8x8 multiplier.
// Define MUL_ARB_RR_EN for round-robin selection; default is fixed priority.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input logic      clk_i,
  input logic      rst_i,
  mul_arb_if.slave bus
);

  state_t           state, state_d;
  logic [N_REQ-1:0] owner, owner_d;
  operands_t        ops, ops_d;
  logic [RES_W-1:0] y, y_d;
  logic [N_REQ-1:0] gnt, gnt_d;
  logic [N_REQ-1:0] done, done_d;
  logic             start, start_d;
  logic             busy, busy_d;

  logic [N_REQ-1:0] win_onehot_c;
  logic [ID_W-1:0]  win_idx_c;
  logic             any_c;

  logic [OP_W-1:0]  a_arr [N_REQ];
  logic [OP_W-1:0]  b_arr [N_REQ];

`ifdef MUL_ARB_RR_EN
  logic [ID_W-1:0]  ptr, ptr_d;
`endif

  // Unpack per-requester operand slices.
  for (genvar k = 0; k < int'(N_REQ); k++) begin : g_slice
    assign a_arr[k] = bus.a_bi[k*OP_W +: OP_W];
    assign b_arr[k] = bus.b_bi[k*OP_W +: OP_W];
  end

  mul_arb_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req         (bus.req_i),
`ifdef MUL_ARB_RR_EN
    .ptr         (ptr),
`endif
    .win_onehot_c(win_onehot_c),
    .win_idx_c   (win_idx_c),
    .any_c       (any_c)
  );

  // Next state, latched job data and next-cycle output values.
  always_comb begin
    state_d = state;
    owner_d = owner;
    ops_d   = ops;
    y_d     = y;
`ifdef MUL_ARB_RR_EN
    ptr_d   = ptr;
`endif
    case (state)
      ST_IDLE: begin
        if (any_c && !bus.mul_busy_i) begin
          owner_d = win_onehot_c;
          ops_d.a = a_arr[win_idx_c];
          ops_d.b = b_arr[win_idx_c];
`ifdef MUL_ARB_RR_EN
          ptr_d   = (win_idx_c == ID_W'(N_REQ - 1)) ? '0 : win_idx_c + ID_W'(1);
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: if (bus.mul_busy_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.mul_busy_i) begin
          y_d     = bus.mul_y_bi;
          state_d = ST_DONE;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    gnt_d   = (state_d == ST_ISSUE) ? owner_d : '0;
    start_d = (state_d == ST_ISSUE);
    done_d  = (state_d == ST_DONE) ? owner_d : '0;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      owner <= '0;
      ops   <= '0;
      y     <= '0;
      gnt   <= '0;
      done  <= '0;
      start <= 1'b0;
      busy  <= 1'b0;
`ifdef MUL_ARB_RR_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_d;
      owner <= owner_d;
      ops   <= ops_d;
      y     <= y_d;
      gnt   <= gnt_d;
      done  <= done_d;
      start <= start_d;
      busy  <= busy_d;
`ifdef MUL_ARB_RR_EN
      ptr   <= ptr_d;
`endif
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.done_o      = done;
  assign bus.y_bo        = y;
  assign bus.busy_o      = busy;
  assign bus.mul_start_o = start;
  assign bus.mul_a_bo    = ops.a;
  assign bus.mul_b_bo    = ops.b;

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: self-checking bench for mul_arb with a behavioural multiplier
// and an event-level reference model of the arbiter.
module tb_mul_arb;
  import mul_arb_pkg::*;

  localparam int unsigned NR = 4;
`ifdef MUL_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_arb_if #(.N_REQ(NR)) bus ();

  mul_arb #(.N_REQ(NR), .ID_W(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] set_byte(input logic [31:0] v, input int k, input logic [7:0] x);
    return (v & ~(32'hFF << (8*k))) | (32'(x) << (8*k));
  endfunction

  // Multiplier: busy 8 cycles after start, junk on y until busy falls.
  logic        m_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic [15:0] m_y = '0;
  logic [15:0] m_p = '0;
  int          m_cnt = 0;
  assign bus.mul_busy_i = m_busy | force_busy;
  assign bus.mul_y_bi   = m_y;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_y <= '0; m_p <= '0;
    end else if (bus.mul_start_o) begin
      m_busy <= 1'b1; m_cnt <= 8;
      m_p <= 16'(bus.mul_a_bo) * 16'(bus.mul_b_bo);
      m_y <= 16'($urandom);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_busy <= 1'b0; m_y <= m_p; end
      else m_y <= 16'($urandom);
    end
  end

  // Reference model: one job record, tracked as events in cycle numbers.
  bit          in_job = 1'b0;
  bit          busy_seen = 1'b0;
  int          grant_at = -1;
  int          done_at = -1;
  int          job_k = 0;
  int          r_ptr = 0;
  logic [7:0]  x_a = '0;
  logic [7:0]  x_b = '0;
  logic [15:0] x_y = '0;

  function automatic int pick_winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (p + i) % 4;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int k;
    int p;
    if (rst) begin
      in_job = 1'b0; busy_seen = 1'b0; grant_at = -1; done_at = -1;
      r_ptr = 0; x_a = '0; x_b = '0; x_y = '0;
    end else if (in_job) begin
      if (cyc == done_at) in_job = 1'b0;
      else if (cyc > grant_at && !busy_seen && bus.mul_busy_i) busy_seen = 1'b1;
      else if (busy_seen && !bus.mul_busy_i && done_at < 0) begin
        done_at = cyc + 1;
        x_y = 16'(x_a) * 16'(x_b);
      end
    end else if (bus.req_i != 4'd0 && !bus.mul_busy_i) begin
      p = RR_EN ? r_ptr : 0;
      k = pick_winner(bus.req_i, p);
      job_k = k;
      x_a = 8'(bus.a_bi >> (8*k));
      x_b = 8'(bus.b_bi >> (8*k));
      in_job = 1'b1; busy_seen = 1'b0; grant_at = cyc + 1; done_at = -1;
      r_ptr = (k + 1) % 4;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] xg;
    logic [3:0] xd;
    if (checking) begin
      xg = (in_job && cyc == grant_at) ? 4'(4'd1 << job_k) : 4'd0;
      xd = (in_job && cyc == done_at)  ? 4'(4'd1 << job_k) : 4'd0;
      check("gnt",   32'(bus.gnt_o),       32'(xg));
      check("start", 32'(bus.mul_start_o), 32'(xg != 4'd0));
      check("done",  32'(bus.done_o),      32'(xd));
      check("busy",  32'(bus.busy_o),      32'(in_job));
      check("y",     32'(bus.y_bo),        32'(x_y));
      check("mul_a", 32'(bus.mul_a_bo),    32'(x_a));
      check("mul_b", 32'(bus.mul_b_bo),    32'(x_b));
    end
  end

  task automatic wait_for(input bit want_done, input int limit, output int at,
                          output logic [3:0] val, output logic [15:0] y, output bit timed_out);
    timed_out = 1'b1; at = -1; val = '0; y = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if ((want_done ? bus.done_o : bus.gnt_o) != 4'd0) begin
        at = cyc; val = want_done ? bus.done_o : bus.gnt_o; y = bus.y_bo; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req_i = '0; force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required under 60000", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int at;
    int prev;
    logic [3:0] v;
    logic [15:0] y;
    bit to;
    logic [3:0] r;
    logic [3:0] drop;

    bus.req_i = '0; bus.a_bi = '0; bus.b_bi = '0;
    do_reset();
    checking = 1'b1;
    @(negedge clk);
    check("rst_gnt",  32'(bus.gnt_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_y",    32'(bus.y_bo), 32'd0);

    // Single request, requester 0: 3*5.
    @(posedge clk); #1; t0 = cyc;
    bus.a_bi = set_byte(32'd0, 0, 8'd3); bus.b_bi = set_byte(32'd0, 0, 8'd5);
    bus.req_i = 4'b0001;
    wait_for(1'b0, 20, at, v, y, to);
    check("t1_gnt_to", 32'(to), 32'd0);
    check("t1_gnt_lat", 32'(at - t0), 32'd1);
    check("t1_gnt", 32'(v), 32'd1);
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t1_done_lat", 32'(at - t0), 32'd11);
    check("t1_done", 32'(v), 32'd1);
    check("t1_y", 32'(y), 32'd15);

    // Full-range operands on requester 2.
    @(posedge clk); #1; t0 = cyc; busy_cnt = 0;
    bus.a_bi = set_byte(bus.a_bi, 2, 8'd255); bus.b_bi = set_byte(bus.b_bi, 2, 8'd255);
    bus.req_i = 4'b0100;
    wait_for(1'b0, 20, at, v, y, to);
    check("t2_gnt", 32'(v), 32'd4);
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t2_done", 32'(v), 32'd4);
    check("t2_y", 32'(y), 32'd65025);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd11);

    // All four requesting from a fresh pointer.
    do_reset();
    bus.a_bi = 32'h04030201; bus.b_bi = 32'h0A0A0A0A;
    bus.req_i = 4'b1111; t0 = cyc; prev = t0 - 11;
    for (int i = 0; i < 5; i++) begin
      wait_for(1'b0, 30, at, v, y, to);
      check("t3_gnt_order", 32'(v), RR_EN ? (32'd1 << (i % 4)) : 32'd1);
      check("t3_gnt_spacing", 32'(at - prev), (i == 0) ? 32'd12 : 32'd12);
      prev = at;
    end
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t3_last_y", 32'(y), 32'd10);

    // Late arrival on requester 1 while requester 0 runs.
    @(posedge clk); #1; t0 = cyc;
    bus.a_bi = set_byte(bus.a_bi, 0, 8'd7); bus.b_bi = set_byte(bus.b_bi, 0, 8'd9);
    bus.req_i = 4'b0001;
    wait_for(1'b0, 20, at, v, y, to);
    check("t4_gnt0", 32'(v), 32'd1);
    @(posedge clk); #1; bus.req_i = '0;
    repeat (3) @(posedge clk); #1;
    bus.a_bi = set_byte(bus.a_bi, 1, 8'd11); bus.b_bi = set_byte(bus.b_bi, 1, 8'd13);
    bus.req_i = 4'b0010;
    @(posedge clk); #1; bus.a_bi = set_byte(bus.a_bi, 0, 8'd99);
    repeat (2) @(posedge clk); #1;
    bus.a_bi = set_byte(bus.a_bi, 1, 8'd20); bus.b_bi = set_byte(bus.b_bi, 1, 8'd30);
    wait_for(1'b1, 20, at, v, y, to);
    check("t4_done0_lat", 32'(at - t0), 32'd11);
    check("t4_y0", 32'(y), 32'd63);
    prev = at;
    wait_for(1'b0, 20, at, v, y, to);
    check("t4_gnt1", 32'(v), 32'd2);
    check("t4_gnt1_lat", 32'(at - prev), 32'd2);
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t4_y1", 32'(y), 32'd600);

    // Reset pulse during RUN.
    @(posedge clk); #1; t0 = cyc;
    bus.a_bi = set_byte(bus.a_bi, 0, 8'd4); bus.b_bi = set_byte(bus.b_bi, 0, 8'd6);
    bus.req_i = 4'b0001;
    wait_for(1'b0, 20, at, v, y, to);
    @(posedge clk); #1; bus.req_i = '0;
    repeat (3) @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(bus.busy_o), 32'd0);
    check("t5_y", 32'(bus.y_bo), 32'd0);
    check("t5_mul_a", 32'(bus.mul_a_bo), 32'd0);
    wait_for(1'b1, 15, at, v, y, to);
    check("t5_no_done", 32'(to), 32'd1);
    @(posedge clk); #1; t0 = cyc;
    bus.a_bi = set_byte(bus.a_bi, 3, 8'd12); bus.b_bi = set_byte(bus.b_bi, 3, 8'd12);
    bus.req_i = 4'b1000;
    wait_for(1'b0, 20, at, v, y, to);
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t5_done", 32'(v), 32'd8);
    check("t5_done_lat", 32'(at - t0), 32'd11);
    check("t5_y", 32'(y), 32'd144);

    // Multiplier busy in IDLE blocks the grant until it falls.
    @(posedge clk); #1; t0 = cyc;
    force_busy = 1'b1;
    bus.a_bi = set_byte(bus.a_bi, 0, 8'd2); bus.b_bi = set_byte(bus.b_bi, 0, 8'd3);
    bus.req_i = 4'b0001;
    repeat (6) @(posedge clk); #1; force_busy = 1'b0;
    wait_for(1'b0, 20, at, v, y, to);
    check("t6_gnt_lat", 32'(at - t0), 32'd7);
    check("t6_gnt", 32'(v), 32'd1);
    @(posedge clk); #1; bus.req_i = '0;
    wait_for(1'b1, 20, at, v, y, to);
    check("t6_y", 32'(y), 32'd6);

    // Random traffic with drops, operand churn, busy glitches and resets.
    drop = '0;
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      r = bus.req_i & ~drop;
      drop = bus.gnt_o;
      for (int k = 0; k < 4; k++) begin
        if (((r >> k) & 4'd1) == 4'd0) begin
          if ($urandom_range(0, 5) == 0) begin
            r = r | 4'(4'd1 << k);
            bus.a_bi = set_byte(bus.a_bi, k, 8'($urandom));
            bus.b_bi = set_byte(bus.b_bi, k, 8'($urandom));
          end
        end else if ($urandom_range(0, 40) == 0) begin
          r = r & ~4'(4'd1 << k);
        end
        if ($urandom_range(0, 15) == 0) bus.a_bi = set_byte(bus.a_bi, k, 8'($urandom));
      end
      bus.req_i  = r;
      force_busy = ($urandom_range(0, 40) == 0);
      rst        = ($urandom_range(0, 300) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; force_busy = 1'b0; bus.req_i = '0;
    repeat (30) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
